// File: rtl/oser_gearbox_if.sv
// rtl/oser_gearbox_if.sv - parallel word handshake into the serial output gearbox
interface oser_gearbox_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] DIN;
   logic             DIN_VALID;
   logic             DIN_READY;

   modport master (output DIN, output DIN_VALID, input DIN_READY);
   modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/oser_gearbox.sv
// rtl/oser_gearbox.sv - parallel-to-serial output gearbox feeding an IO-cell output flop
// Holding register plus shift register so consecutive words stream with no idle bits.
module oser_gearbox #(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b1,
   parameter bit   LSB_FIRST  = 1'b1
) (
   input  logic         SCLK,
   input  logic         RST,
   oser_gearbox_if.slave din_bus,
   input  logic         CONT,
   input  logic         CLR_UNDERRUN,
   output logic         TXD,
   output logic         TXEN,
   output logic         BUSY,
   output logic         UNDERRUN
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic             hold_full;
   logic             active;
   logic [WIDTH-1:0] hold_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    cnt;

   logic drain, xfer, load, last, hold_full_n, active_n;

   // drain: shift register is free or on its final bit, so HOLD may move in now
   assign drain       = !active || (cnt == LAST_CNT);
   assign din_bus.DIN_READY = !RST && (!hold_full || drain);
   assign xfer        = din_bus.DIN_VALID && din_bus.DIN_READY;
   assign load        = drain && hold_full;
   assign last        = active && (cnt == LAST_CNT);
   assign hold_full_n = xfer || (hold_full && !load);
   assign active_n    = load || (active && !last);

   always_ff @(posedge SCLK) begin
      if (RST) begin
         hold_full <= 1'b0;
         active    <= 1'b0;
         hold_q    <= '0;
         shift_q   <= '0;
         cnt       <= '0;
         TXD       <= IDLE_LEVEL;
         TXEN      <= 1'b0;
         BUSY      <= 1'b0;
         UNDERRUN  <= 1'b0;
      end else begin
         hold_full <= hold_full_n;
         active    <= active_n;
         BUSY      <= hold_full_n || active_n;

         if (xfer)
            hold_q <= din_bus.DIN;

         if (load) begin
            shift_q <= hold_q;
            cnt     <= '0;
            TXD     <= LSB_FIRST ? hold_q[0] : hold_q[WIDTH-1];
            TXEN    <= 1'b1;
         end else if (active && !drain) begin
            // the bit on TXD is always at the output end of shift_q
            cnt <= cnt + CW'(1);
            if (LSB_FIRST) begin
               shift_q <= shift_q >> 1;
               TXD     <= shift_q[1];
            end else begin
               shift_q <= shift_q << 1;
               TXD     <= shift_q[WIDTH-2];
            end
         end else if (last) begin
            TXEN <= 1'b0;
            TXD  <= IDLE_LEVEL;
         end

         if (last && !hold_full && CONT)
            UNDERRUN <= 1'b1;
         else if (CLR_UNDERRUN)
            UNDERRUN <= 1'b0;
      end
   end
endmodule

// File: tb/tb_oser_gearbox.sv
// tb/tb_oser_gearbox.sv - directed and scoreboard bench for oser_gearbox
module tb_oser_gearbox;
   logic SCLK = 1'b0;
   logic RST = 1'b1;
   logic CONT = 1'b0;
   logic CLR_UNDERRUN = 1'b0;
   logic TXD, TXEN, BUSY, UNDERRUN;
   logic TXD2, TXEN2, BUSY2, UNDERRUN2;

   int n_cmp = 0;
   int n_bad = 0;

   oser_gearbox_if #(.WIDTH(8)) bus ();
   oser_gearbox_if #(.WIDTH(8)) bus2 ();

   oser_gearbox #(.WIDTH(8), .IDLE_LEVEL(1'b1), .LSB_FIRST(1'b1)) u_dut (
      .SCLK(SCLK), .RST(RST), .din_bus(bus), .CONT(CONT), .CLR_UNDERRUN(CLR_UNDERRUN),
      .TXD(TXD), .TXEN(TXEN), .BUSY(BUSY), .UNDERRUN(UNDERRUN));

   oser_gearbox #(.WIDTH(8), .IDLE_LEVEL(1'b1), .LSB_FIRST(1'b0)) u_msb (
      .SCLK(SCLK), .RST(RST), .din_bus(bus2), .CONT(CONT), .CLR_UNDERRUN(CLR_UNDERRUN),
      .TXD(TXD2), .TXEN(TXEN2), .BUSY(BUSY2), .UNDERRUN(UNDERRUN2));

   always #5 SCLK = ~SCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge SCLK);
      #1;
   endtask

   task automatic send(input logic [7:0] w);
      check("send_ready", bus.DIN_READY, 1);
      bus.DIN = w;
      bus.DIN_VALID = 1'b1;
      tick();
      bus.DIN_VALID = 1'b0;
   endtask

   // scoreboard state for the random run
   bit q_bits[$];
   int bit_bad = 0, idle_bad = 0, run_bad = 0, run_len = 0, n_bits = 0;

   task automatic monitor();
      if (TXEN) begin
         run_len++;
         n_bits++;
         if (q_bits.size() == 0) bit_bad++;
         else if (TXD !== q_bits.pop_front()) bit_bad++;
      end else begin
         if (TXD !== 1'b1) idle_bad++;
         if (run_len % 8 != 0) run_bad++;
         run_len = 0;
      end
   endtask

   initial begin
      logic [7:0] exp_seq;
      logic [7:0] words [3];
      logic [23:0] got_stream, exp_stream;
      int idx, rdy_low, txen_total, cur_run, max_run, txcnt, sent, cyc;
      bit acc;
      logic [7:0] w;

      bus.DIN = '0;  bus.DIN_VALID = 1'b0;
      bus2.DIN = '0; bus2.DIN_VALID = 1'b0;

      // reset state
      repeat (3) tick();
      check("rst_txd", TXD, 1);
      check("rst_txen", TXEN, 0);
      check("rst_busy", BUSY, 0);
      check("rst_underrun", UNDERRUN, 0);
      check("rst_ready", bus.DIN_READY, 0);
      check("rst_msb_txd", TXD2, 1);
      RST = 1'b0;
      tick();
      check("ready_after_rst", bus.DIN_READY, 1);

      // single word, LSB first
      exp_seq = 8'b1_0_1_0_0_1_0_1;
      send(8'hA5);
      check("a5_txen_k", TXEN, 0);
      check("a5_busy_k", BUSY, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("a5_txen_%0d", i), TXEN, 1);
         check($sformatf("a5_txd_%0d", i), TXD, exp_seq[7-i]);
      end
      tick();
      check("a5_end_txen", TXEN, 0);
      check("a5_end_txd", TXD, 1);
      check("a5_end_busy", BUSY, 0);

      // back-to-back stream of three words
      words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'h3C;
      exp_stream = {8'h3C, 8'hF0, 8'h0F};
      got_stream = '0;
      idx = 0; rdy_low = 0; txen_total = 0; cur_run = 0; max_run = 0;
      bus.DIN = words[0];
      bus.DIN_VALID = 1'b1;
      for (int c = 0; c < 32; c++) begin
         acc = bus.DIN_VALID && bus.DIN_READY;
         tick();
         if (acc) begin
            idx++;
            if (idx < 3) bus.DIN = words[idx];
            else bus.DIN_VALID = 1'b0;
         end
         if (!bus.DIN_READY) rdy_low++;
         if (TXEN) begin
            if (txen_total < 24) got_stream[txen_total] = TXD;
            txen_total++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
         end else begin
            cur_run = 0;
         end
      end
      check("stream_accepted", idx, 3);
      check("stream_txen_total", txen_total, 24);
      check("stream_max_run", max_run, 24);
      check("stream_bits", got_stream, exp_stream);
      check("stream_ready_low", rdy_low, 14);
      check("stream_underrun", UNDERRUN, 0);

      // MSB-first instance
      exp_seq = 8'b1_0_0_0_0_0_0_0;
      bus2.DIN = 8'h80;
      bus2.DIN_VALID = 1'b1;
      tick();
      bus2.DIN_VALID = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("msb_txen_%0d", i), TXEN2, 1);
         check($sformatf("msb_txd_%0d", i), TXD2, exp_seq[7-i]);
      end
      tick();
      check("msb_end_txen", TXEN2, 0);
      check("msb_end_txd", TXD2, 1);

      // underrun flag in continuous mode
      CONT = 1'b1;
      send(8'h55);
      repeat (8) tick();
      check("ur_last_bit_txen", TXEN, 1);
      check("ur_before_end", UNDERRUN, 0);
      tick();
      check("ur_set", UNDERRUN, 1);
      check("ur_set_txen", TXEN, 0);
      repeat (3) tick();
      check("ur_sticky", UNDERRUN, 1);
      send(8'h33);
      repeat (8) tick();
      CLR_UNDERRUN = 1'b1;
      tick();
      CLR_UNDERRUN = 1'b0;
      check("ur_set_wins", UNDERRUN, 1);
      CLR_UNDERRUN = 1'b1;
      tick();
      CLR_UNDERRUN = 1'b0;
      check("ur_clr", UNDERRUN, 0);
      CONT = 1'b0;
      tick();

      // reset mid-word with a second word held
      send(8'hFF);
      bus.DIN = 8'h12;
      bus.DIN_VALID = 1'b1;
      tick();
      bus.DIN_VALID = 1'b0;
      repeat (3) tick();
      check("mid_txen", TXEN, 1);
      check("mid_txd", TXD, 1);
      check("mid_ready", bus.DIN_READY, 0);
      RST = 1'b1;
      #1;
      check("mid_rst_ready", bus.DIN_READY, 0);
      tick();
      check("mid_rst_txen", TXEN, 0);
      check("mid_rst_txd", TXD, 1);
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_ready2", bus.DIN_READY, 0);
      RST = 1'b0;
      txcnt = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (TXEN) txcnt++;
      end
      check("mid_no_residual", txcnt, 0);
      check("mid_idle_busy", BUSY, 0);

      // random valid gaps against a bit scoreboard
      sent = 0; cyc = 0;
      while (sent < 1000 && cyc < 20000) begin
         bus.DIN_VALID = ($urandom_range(0, 9) < 7);
         w = 8'($urandom);
         bus.DIN = w;
         acc = bus.DIN_VALID && bus.DIN_READY;
         tick();
         cyc++;
         if (acc) begin
            for (int b = 0; b < 8; b++) q_bits.push_back(w[b]);
            sent++;
         end
         monitor();
      end
      bus.DIN_VALID = 1'b0;
      repeat (30) begin
         tick();
         monitor();
      end
      check("rand_words", sent, 1000);
      check("rand_bits_sent", n_bits, 8000);
      check("rand_bit_errors", bit_bad, 0);
      check("rand_idle_level", idle_bad, 0);
      check("rand_run_length", run_bad, 0);
      check("rand_queue_empty", q_bits.size(), 0);
      check("rand_underrun", UNDERRUN, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
